cozy_regfile_arbiter: RTL and testbench

Sequencer and arbiter that sits in front of `cozy_registerfile` and owns its rD port. After reset it clears R1–R15, then shares the rD port between the CPU datapath and a debug requester. The CPU has default priority; a starvation counter forces a one-cycle CPU stall so that debug accesses always complete. The rS port passes through from the CPU untouched.

---
 rtl/cozy_regfile_arbiter_pkg.sv | 15 +
 rtl/cozy_regfile_arbiter.sv | 124 ++++++++++++
 tb/tb_cozy_regfile_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cozy_regfile_arbiter_pkg.sv
// Shared definitions for the register-file rD-port arbiter: state encodings
// and the range of registers cleared after reset.
package cozy_regfile_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DBG  = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  localparam logic [3:0] CLR_FIRST = 4'd1;
  localparam logic [3:0] CLR_LAST  = 4'd15;

endpackage

// File: rtl/cozy_regfile_arbiter.sv
// Owns the register file rD port: clears R1-R15 after reset, then shares the
// port between the CPU (default priority) and a starvation-bounded debug port.
module cozy_regfile_arbiter
  import cozy_regfile_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_rD_sel,
  input  logic        cpu_rD_we,
  input  logic [15:0] cpu_rD_in,
  input  logic [3:0]  cpu_rS_sel,
  output logic [15:0] cpu_rD_out,
  output logic [15:0] cpu_rS_out,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [3:0]  dbg_sel,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [15:0] dbg_rdata,
  output logic        init_busy,
  output logic [3:0]  rf_rD_sel,
  output logic        rf_rD_we,
  output logic [15:0] rf_rD_in,
  output logic [3:0]  rf_rS_sel,
  input  logic [15:0] rf_rD_out,
  input  logic [15:0] rf_rS_out,
  output logic [1:0]  dbg_state
);

  localparam logic [7:0] STARVE_LAST = 8'(STARVE_LIMIT - 1);

  // Handshake: dbg_req rises with dbg_we/dbg_sel/dbg_wdata stable; dbg_ack
  // stays high until dbg_req falls, and each request yields one access.
  state_e      state_q, state_d;
  logic [3:0]  clr_cnt_q, clr_cnt_d;
  logic [7:0]  starve_q, starve_d;
  logic [15:0] dbg_rdata_q, dbg_rdata_d;
  logic [15:0] dbg_capture;

  // R0 always reads as zero; a write is observed as the value written.
  always_comb begin
    if (dbg_sel == 4'd0)  dbg_capture = 16'h0000;
    else if (dbg_we)      dbg_capture = dbg_wdata;
    else                  dbg_capture = rf_rD_out;
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    starve_d    = starve_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      ST_INIT: begin
        clr_cnt_d = clr_cnt_q + 4'd1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d   = ST_RUN;
          clr_cnt_d = CLR_FIRST;
        end
      end
      ST_RUN: begin
        if (dbg_req && (!cpu_en || starve_q == STARVE_LAST)) begin
          state_d  = ST_DBG;
          starve_d = 8'd0;
        end else if (dbg_req && cpu_en) begin
          starve_d = starve_q + 8'd1;
        end
      end
      ST_DBG: begin
        dbg_rdata_d = dbg_capture;
        state_d     = ST_ACK;
      end
      default: begin
        if (!dbg_req) state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= CLR_FIRST;
      starve_q    <= 8'd0;
      dbg_rdata_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      starve_q    <= starve_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    rf_rD_sel = cpu_rD_sel;
    rf_rD_we  = cpu_rD_we & cpu_en;
    rf_rD_in  = cpu_rD_in;
    case (state_q)
      ST_INIT: begin
        rf_rD_sel = clr_cnt_q;
        rf_rD_we  = 1'b1;
        rf_rD_in  = 16'h0000;
      end
      ST_DBG: begin
        rf_rD_sel = dbg_sel;
        rf_rD_we  = dbg_we;
        rf_rD_in  = dbg_wdata;
      end
      default: ;
    endcase
  end

  assign rf_rS_sel  = cpu_rS_sel;
  assign cpu_rD_out = rf_rD_out;
  assign cpu_rS_out = rf_rS_out;
  assign cpu_stall  = (state_q == ST_INIT) || (state_q == ST_DBG);
  assign init_busy  = (state_q == ST_INIT);
  assign dbg_ack    = (state_q == ST_ACK);
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cozy_regfile_arbiter.sv
// Bench for cozy_regfile_arbiter with a behavioural 16x16 register file and
// a queue of expected debug read data.
module tb_cozy_regfile_arbiter;
  import cozy_regfile_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_en = 1'b0;
  logic [3:0]  cpu_rD_sel = 4'd0;
  logic        cpu_rD_we = 1'b0;
  logic [15:0] cpu_rD_in = 16'h0;
  logic [3:0]  cpu_rS_sel = 4'd0;
  logic [15:0] cpu_rD_out, cpu_rS_out;
  logic        cpu_stall;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [3:0]  dbg_sel = 4'd0;
  logic [15:0] dbg_wdata = 16'h0;
  logic        dbg_ack;
  logic [15:0] dbg_rdata;
  logic        init_busy;
  logic [3:0]  rf_rD_sel, rf_rS_sel;
  logic        rf_rD_we;
  logic [15:0] rf_rD_in, rf_rD_out, rf_rS_out;
  logic [1:0]  dbg_state;

  logic [15:0] mem [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_sel = 4'd0;
  logic [15:0] pl_val = 16'h0;
  int          wr_count = 0;

  logic [15:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  cozy_regfile_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_rD_sel(cpu_rD_sel),
    .cpu_rD_we(cpu_rD_we), .cpu_rD_in(cpu_rD_in), .cpu_rS_sel(cpu_rS_sel),
    .cpu_rD_out(cpu_rD_out), .cpu_rS_out(cpu_rS_out), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_sel(dbg_sel), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .init_busy(init_busy),
    .rf_rD_sel(rf_rD_sel), .rf_rD_we(rf_rD_we), .rf_rD_in(rf_rD_in),
    .rf_rS_sel(rf_rS_sel), .rf_rD_out(rf_rD_out), .rf_rS_out(rf_rS_out),
    .dbg_state(dbg_state)
  );

  // Register file model; the preload path lets the bench seed contents.
  always @(posedge clk) begin
    if (pl_en) mem[pl_sel] <= pl_val;
    else if (rf_rD_we) begin
      mem[rf_rD_sel] <= rf_rD_in;
      wr_count <= wr_count + 1;
    end
  end
  assign rf_rD_out = mem[rf_rD_sel];
  assign rf_rS_out = mem[rf_rS_sel];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] sel, input logic [15:0] val);
    pl_en = 1'b1; pl_sel = sel; pl_val = val;
    step();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    step();
    checks++;
    if (init_busy !== 1'b1 || cpu_stall !== 1'b1 || dbg_ack !== 1'b0 || dbg_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b stall=%b ack=%b rdata=%h, need 1 1 0 0000",
               init_busy, cpu_stall, dbg_ack, dbg_rdata);
    end
    checks++;
    if (rf_rD_sel !== 4'd1 || rf_rD_we !== 1'b1 || rf_rD_in !== 16'h0) begin
      errors++;
      $display("FAIL reset_port: sel=%0d we=%b in=%h, need 1 1 0000", rf_rD_sel, rf_rD_we, rf_rD_in);
    end
    for (int i = 0; i < 16; i++) preload(4'(i), 16'(i) * 16'h1111);
    rst = 1'b0;
    bad = 0;
    for (int i = 1; i <= 15; i++) begin
      if (init_busy !== 1'b1 || cpu_stall !== 1'b1 || rf_rD_sel !== 4'(i) || rf_rD_we !== 1'b1 ||
          rf_rD_in !== 16'h0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_sequence: %0d bad cycles, need 0", bad);
    end
    checks++;
    if (init_busy !== 1'b0 || cpu_stall !== 1'b0 || dbg_state !== ST_RUN) begin
      errors++;
      $display("FAIL clear_done: busy=%b stall=%b state=%0d, need 0 0 1", init_busy, cpu_stall, dbg_state);
    end
    bad = 0;
    for (int i = 1; i <= 15; i++) if (mem[i] !== 16'h0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_contents: %0d registers nonzero, need 0", bad);
    end
  endtask

  task automatic test_passthrough();
    logic [3:0] s, d;
    int bad;
    bad = 0;
    for (int k = 0; k < 6; k++) preload(4'(k + 8), 16'($urandom_range(0, 65535)));
    for (int k = 0; k < 6; k++) begin
      s = 4'($urandom_range(0, 15));
      d = 4'($urandom_range(0, 15));
      cpu_rS_sel = s; cpu_rD_sel = d;
      #1;
      if (rf_rS_sel !== s || cpu_rS_out !== mem[s] || cpu_rD_out !== mem[d] || rf_rD_sel !== d) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL passthrough: %0d bad samples, need 0", bad);
    end
  endtask

  task automatic test_dbg_write_idle();
    int n;
    logic [15:0] exp_v;
    cpu_en = 1'b0;
    dbg_we = 1'b1; dbg_sel = 4'd3; dbg_wdata = 16'haa55; dbg_req = 1'b1;
    exp_q.push_back(16'haa55);
    step();
    checks++;
    if (dbg_state !== ST_DBG || cpu_stall !== 1'b1 || rf_rD_sel !== 4'd3 || rf_rD_we !== 1'b1 ||
        rf_rD_in !== 16'haa55 || dbg_ack !== 1'b0) begin
      errors++;
      $display("FAIL dbg_cycle: state=%0d stall=%b sel=%0d we=%b in=%h ack=%b, need 2 1 3 1 aa55 0",
               dbg_state, cpu_stall, rf_rD_sel, rf_rD_we, rf_rD_in, dbg_ack);
    end
    n = 1;
    while (dbg_ack !== 1'b1 && n < 10) begin step(); n++; end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL dbg_latency: ack after %0d edges, need 2", n);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (dbg_rdata !== exp_v || mem[3] !== 16'haa55) begin
      errors++;
      $display("FAIL dbg_write: rdata=%h R3=%h, need %h aa55", dbg_rdata, mem[3], exp_v);
    end
    dbg_req = 1'b0; dbg_we = 1'b0;
    step();
  endtask

  task automatic test_dbg_read_r0();
    int n;
    logic [15:0] exp_v;
    preload(4'd0, 16'h1234);
    dbg_we = 1'b0; dbg_sel = 4'd0; dbg_req = 1'b1;
    exp_q.push_back(16'h0000);
    n = 0;
    while (dbg_ack !== 1'b1 && n < 10) begin step(); n++; end
    exp_v = exp_q.pop_front();
    checks++;
    if (n >= 10 || dbg_rdata !== exp_v || mem[0] !== 16'h1234) begin
      errors++;
      $display("FAIL dbg_read_r0: rdata=%h R0=%h edges=%0d, need %h 1234", dbg_rdata, mem[0], n, exp_v);
    end
    dbg_req = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    int n, stalls;
    logic [15:0] last_cpu, wd, exp_v;
    wd = 16'($urandom_range(1, 65535));
    cpu_en = 1'b1; cpu_rD_we = 1'b1; cpu_rD_sel = 4'd7; cpu_rD_in = 16'($urandom_range(0, 65535));
    dbg_we = 1'b1; dbg_sel = 4'd9; dbg_wdata = wd; dbg_req = 1'b1;
    exp_q.push_back(wd);
    n = 0; stalls = 0; last_cpu = cpu_rD_in;
    while (dbg_state !== ST_DBG && n < 20) begin
      if (cpu_stall) stalls++;
      last_cpu = cpu_rD_in;
      step();
      n++;
      if (dbg_state !== ST_DBG) cpu_rD_in = 16'($urandom_range(0, 65535));
      else cpu_rD_in = ~last_cpu;
    end
    checks++;
    if (n != 8 || stalls != 0) begin
      errors++;
      $display("FAIL starve_wait: DBG after %0d cycles with %0d stalls, need 8 and 0", n, stalls);
    end
    checks++;
    if (cpu_stall !== 1'b1 || rf_rD_sel !== 4'd9 || rf_rD_in !== wd) begin
      errors++;
      $display("FAIL starve_dbg: stall=%b sel=%0d in=%h, need 1 9 %h", cpu_stall, rf_rD_sel, rf_rD_in, wd);
    end
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (mem[7] !== last_cpu || mem[9] !== wd || cpu_stall !== 1'b0 || dbg_ack !== 1'b1 || dbg_rdata !== exp_v) begin
      errors++;
      $display("FAIL starve_ack: R7=%h R9=%h stall=%b ack=%b rdata=%h, need %h %h 0 1 %h",
               mem[7], mem[9], cpu_stall, dbg_ack, dbg_rdata, last_cpu, wd, exp_v);
    end
    step();
    checks++;
    if (mem[7] !== ~last_cpu) begin
      errors++;
      $display("FAIL cpu_during_ack: R7=%h, need %h", mem[7], ~last_cpu);
    end
    dbg_req = 1'b0; cpu_en = 1'b0; cpu_rD_we = 1'b0;
    step();
  endtask

  task automatic test_handshake_hold();
    int n, w0, bad;
    logic [15:0] wd, exp_v;
    wd = 16'($urandom_range(1, 65535));
    cpu_en = 1'b0;
    dbg_we = 1'b1; dbg_sel = 4'd4; dbg_wdata = wd; dbg_req = 1'b1;
    exp_q.push_back(wd);
    w0 = wr_count;
    n = 0;
    while (dbg_ack !== 1'b1 && n < 10) begin step(); n++; end
    exp_v = exp_q.pop_front();
    checks++;
    if (n >= 10 || dbg_rdata !== exp_v) begin
      errors++;
      $display("FAIL hold_rdata: rdata=%h edges=%0d, need %h", dbg_rdata, n, exp_v);
    end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (dbg_ack !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_ack: ack low in %0d of 5 cycles, need 0", bad);
    end
    dbg_req = 1'b0;
    step();
    checks++;
    if (dbg_state !== ST_RUN || dbg_ack !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: state=%0d ack=%b, need 1 0", dbg_state, dbg_ack);
    end
    checks++;
    if (wr_count - w0 != 1 || mem[4] !== wd) begin
      errors++;
      $display("FAIL hold_writes: %0d writes R4=%h, need 1 %h", wr_count - w0, mem[4], wd);
    end
    dbg_we = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    int bad;
    logic [15:0] r5;
    r5 = mem[5];
    cpu_en = 1'b0;
    dbg_we = 1'b1; dbg_sel = 4'd5; dbg_wdata = 16'hbeef; dbg_req = 1'b1;
    step();
    checks++;
    if (dbg_state !== ST_DBG) begin
      errors++;
      $display("FAIL mid_enter: state=%0d, need 2", dbg_state);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (dbg_ack !== 1'b0 || init_busy !== 1'b1 || rf_rD_sel !== 4'd1 || dbg_state !== ST_INIT) begin
      errors++;
      $display("FAIL mid_reset: ack=%b busy=%b sel=%0d state=%0d, need 0 1 1 0",
               dbg_ack, init_busy, rf_rD_sel, dbg_state);
    end
    step();
    checks++;
    if (mem[5] !== r5) begin
      errors++;
      $display("FAIL mid_lost_write: R5=%h, need %h", mem[5], r5);
    end
    dbg_req = 1'b0; dbg_we = 1'b0;
    rst = 1'b0;
    bad = 0;
    for (int i = 1; i <= 15; i++) begin
      if (rf_rD_sel !== 4'(i) || init_busy !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0 || init_busy !== 1'b0 || mem[5] !== 16'h0) begin
      errors++;
      $display("FAIL mid_reclear: %0d bad cycles busy=%b R5=%h, need 0 0 0000", bad, init_busy, mem[5]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_passthrough();
    test_dbg_write_idle();
    test_dbg_read_r0();
    test_starvation();
    test_handshake_hold();
    test_reset_mid_access();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, need 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
